// File: rtl/mips_dmem_io_responder_pkg.sv
// Shared constants and types for the MIPS data-memory / IO responder.
// Address offsets are relative to IO_BASE; timer offsets are only decoded when MIPS_DMEM_TIMER_EN is defined.
package mips_dmem_io_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  localparam logic [15:0] GPIO_OUT_OFS = 16'h0000;
  localparam logic [15:0] GPIO_IN_OFS  = 16'h0004;
  localparam logic [15:0] TCTRL_OFS    = 16'h0010;
  localparam logic [15:0] TCOUNT_OFS   = 16'h0014;
  localparam logic [15:0] TCMP_OFS     = 16'h0018;
  localparam logic [15:0] TSTAT_OFS    = 16'h001C;

  localparam int EN_BIT   = 0;
  localparam int AUTO_BIT = 1;

  localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

  // Encoding equals memaddr[3:2] within the timer window 0x10..0x1C.
  typedef enum logic [1:0] {
    TREG_CTRL  = 2'd0,
    TREG_COUNT = 2'd1,
    TREG_CMP   = 2'd2,
    TREG_STAT  = 2'd3
  } timer_reg_e;

endpackage

// File: rtl/mips_dmem_io_responder_if.sv
// MEM-stage data bus between the MIPS core (master) and the memory/IO responder (slave).
interface mips_dmem_io_responder_if;

  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;

  modport master (
    output memwrite,
    output memaddr,
    output memwritedata,
    input  memreaddata
  );

  modport slave (
    input  memwrite,
    input  memaddr,
    input  memwritedata,
    output memreaddata
  );

endinterface

// File: rtl/mips_dmem_timer.sv
// Timer/compare peripheral: prescaler, TCTRL/TCOUNT/TCMP/TSTAT and the match interrupt.
// Only compiled when MIPS_DMEM_TIMER_EN is defined.
`ifdef MIPS_DMEM_TIMER_EN
module mips_dmem_timer
  import mips_dmem_io_responder_pkg::*;
#(
  parameter int PRESC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  timer_reg_e  reg_sel,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam logic [31:0] PRESC_LAST = 32'(PRESC - 1);

  logic [1:0]  ctrl_q, ctrl_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic [31:0] presc_q, presc_d;
  logic        match_q, match_d;
  logic        tick;

  assign tick = ctrl_q[EN_BIT] && (presc_q == PRESC_LAST);

  // Order matters: W1C first so a match can override it, then the tick,
  // then CPU writes to TCTRL/TCOUNT/TCMP so they override the tick.
  always_comb begin
    ctrl_d  = ctrl_q;
    count_d = count_q;
    cmp_d   = cmp_q;
    match_d = match_q;
    presc_d = 32'd0;

    if (ctrl_q[EN_BIT]) begin
      presc_d = tick ? 32'd0 : presc_q + 32'd1;
    end

    if (wr_en && reg_sel == TREG_STAT && wdata[0]) begin
      match_d = 1'b0;
    end

    if (tick) begin
      if (count_q == cmp_q) begin
        match_d = 1'b1;
        if (ctrl_q[AUTO_BIT]) begin
          count_d = 32'd0;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
        end
      end else begin
        count_d = count_q + 32'd1;
      end
    end

    if (wr_en) begin
      case (reg_sel)
        TREG_CTRL:  ctrl_d  = wdata[1:0];
        TREG_COUNT: count_d = wdata;
        TREG_CMP:   cmp_d   = wdata;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= 2'b00;
      count_q <= 32'd0;
      cmp_q   <= TCMP_RST;
      presc_q <= 32'd0;
      match_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      count_q <= count_d;
      cmp_q   <= cmp_d;
      presc_q <= presc_d;
      match_q <= match_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (reg_sel)
      TREG_CTRL:  rdata = {30'd0, ctrl_q};
      TREG_COUNT: rdata = count_q;
      TREG_CMP:   rdata = cmp_q;
      TREG_STAT:  rdata = {31'd0, match_q};
      default:    rdata = 32'd0;
    endcase
  end

  assign irq = match_q;

endmodule
`endif

// File: rtl/mips_dmem_io_responder.sv
// Data-side responder for the pipelined MIPS core: word RAM, GPIO and an optional timer.
// Define MIPS_DMEM_TIMER_EN to build the timer; otherwise its window reads 0 and timer_irq is 0.
module mips_dmem_io_responder
  import mips_dmem_io_responder_pkg::*;
#(
  parameter int RAM_AW = 10,
  parameter int GPIO_W = 16,
  parameter int PRESC  = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  mips_dmem_io_responder_if.slave bus,
  input  logic [GPIO_W-1:0]      gpio_in,
  output logic [GPIO_W-1:0]      gpio_out,
  output logic                   timer_irq
);

  localparam int unsigned RAM_WORDS = 2 ** RAM_AW;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;
  logic [GPIO_W-1:0] sync1_q, sync1_d;
  logic [GPIO_W-1:0] sync2_q, sync2_d;

  logic [15:0]       io_ofs;
  logic              io_page;
  logic              ram_sel;
  logic              timer_hit;
  logic              wr_ok;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       timer_rdata;
  logic [31:0]       rdata;
  logic              unused_bits;

  assign unused_bits = ^bus.memaddr[1:0];

  assign io_ofs    = {bus.memaddr[15:2], 2'b00};
  assign io_page   = (bus.memaddr[31:16] == IO_BASE[31:16]);
  assign ram_sel   = (bus.memaddr[31:16] == 16'h0000) &&
                     ({18'd0, bus.memaddr[15:2]} < RAM_WORDS);
  assign ram_idx   = bus.memaddr[RAM_AW+1:2];
  assign timer_hit = io_page && (io_ofs >= TCTRL_OFS) && (io_ofs <= TSTAT_OFS);
  // A store issued while reset is held low must not reach any target.
  assign wr_ok     = bus.memwrite && reset;

  always_ff @(posedge clk) begin
    if (wr_ok && ram_sel) begin
      ram_q[ram_idx] <= bus.memwritedata;
    end
  end

  always_comb begin
    gpio_out_d = gpio_out_q;
    if (wr_ok && io_page && io_ofs == GPIO_OUT_OFS) begin
      gpio_out_d = bus.memwritedata[GPIO_W-1:0];
    end
    sync1_d = gpio_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      gpio_out_q <= gpio_out_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
    end
  end

  assign gpio_out = gpio_out_q;

`ifdef MIPS_DMEM_TIMER_EN
  mips_dmem_timer #(
    .PRESC (PRESC)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok && timer_hit),
    .reg_sel (timer_reg_e'(bus.memaddr[3:2])),
    .wdata   (bus.memwritedata),
    .rdata   (timer_rdata),
    .irq     (timer_irq)
  );
`else
  logic [31:0] unused_presc;
  assign unused_presc = 32'(PRESC);
  assign timer_rdata  = 32'd0;
  assign timer_irq    = 1'b0;
`endif

  // Combinational read of pre-edge state; the core registers it at MEM/WB.
  always_comb begin
    rdata = 32'd0;
    if (ram_sel) begin
      rdata = ram_q[ram_idx];
    end else if (timer_hit) begin
      rdata = timer_rdata;
    end else if (io_page) begin
      case (io_ofs)
        GPIO_OUT_OFS: rdata[GPIO_W-1:0] = gpio_out_q;
        GPIO_IN_OFS:  rdata[GPIO_W-1:0] = sync2_q;
        default:      rdata = 32'd0;
      endcase
    end
  end

  assign bus.memreaddata = rdata;

endmodule

// File: tb/tb_mips_dmem_io_responder.sv
// Self-checking bench for mips_dmem_io_responder; load results go through a scoreboard queue.
// Timer scenarios run when MIPS_DMEM_TIMER_EN is defined, otherwise the timer window is checked to read 0.
module tb_mips_dmem_io_responder;

  localparam int GPIO_W = 16;

  localparam logic [31:0] A_GPIO_OUT = 32'hFFFF_0000;
  localparam logic [31:0] A_GPIO_IN  = 32'hFFFF_0004;
  localparam logic [31:0] A_TCTRL    = 32'hFFFF_0010;
  localparam logic [31:0] A_TCOUNT   = 32'hFFFF_0014;
  localparam logic [31:0] A_TCMP     = 32'hFFFF_0018;
  localparam logic [31:0] A_TSTAT    = 32'hFFFF_001C;

  typedef struct {
    string       tag;
    logic [31:0] value;
  } expect_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [GPIO_W-1:0] gpio_in;
  logic [GPIO_W-1:0] gpio_out;
  logic              timer_irq;

  int      checkCount = 0;
  int      errorCount = 0;
  expect_t expectQ[$];

  mips_dmem_io_responder_if bus ();

  mips_dmem_io_responder #(
    .RAM_AW (10),
    .GPIO_W (GPIO_W),
    .PRESC  (1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #10 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // One store: strobe held across exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    bus.memaddr      = addr;
    bus.memwritedata = data;
    bus.memwrite     = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite     = 1'b0;
  endtask

  task automatic expectRead(input string tag, input logic [31:0] addr, input logic [31:0] value);
    expect_t e;
    expectQ.push_back('{tag, value});
    bus.memaddr = addr;
    #1;
    e = expectQ.pop_front();
    checkOutput(e.tag, bus.memreaddata, e.value);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.memwrite     = 1'b0;
    bus.memaddr      = 32'd0;
    bus.memwritedata = 32'd0;
    gpio_in          = '0;
    reset            = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    $display("[TB] reset released");

    checkOutput("rst_gpio_out", 32'(gpio_out), 32'd0);
    checkOutput("rst_irq", {31'd0, timer_irq}, 32'd0);
    expectRead("rst_rd_gpio_out", A_GPIO_OUT, 32'd0);
    expectRead("rst_rd_gpio_in", A_GPIO_IN, 32'd0);
    expectRead("rst_tctrl", A_TCTRL, 32'd0);
    expectRead("rst_tcount", A_TCOUNT, 32'd0);
`ifdef MIPS_DMEM_TIMER_EN
    expectRead("rst_tcmp", A_TCMP, 32'hFFFF_FFFF);
`else
    expectRead("rst_tcmp", A_TCMP, 32'd0);
`endif

    // RAM store/load, same-cycle read-old, unmapped and boundary addresses
    applyStimulus(32'h0000_0040, 32'h1234_5678);
    expectRead("ram_40", 32'h0000_0040, 32'h1234_5678);
    expectRead("unmapped_10000", 32'h0001_0000, 32'd0);
    bus.memaddr      = 32'h0000_0040;
    bus.memwritedata = 32'hDEAD_BEEF;
    bus.memwrite     = 1'b1;
    expectQ.push_back('{"ram_same_cycle_old", 32'h1234_5678});
    #1;
    begin
      expect_t e;
      e = expectQ.pop_front();
      checkOutput(e.tag, bus.memreaddata, e.value);
    end
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    expectRead("ram_40_new", 32'h0000_0040, 32'hDEAD_BEEF);
    applyStimulus(32'h0000_0000, 32'hCAFE_0000);
    applyStimulus(32'h0001_0000, 32'h5555_5555);
    applyStimulus(32'h0000_1000, 32'h7777_7777);
    applyStimulus(32'h0000_0FFC, 32'h0BAD_F00D);
    expectRead("ram_0_no_alias", 32'h0000_0000, 32'hCAFE_0000);
    expectRead("ram_top_word", 32'h0000_0FFC, 32'h0BAD_F00D);
    expectRead("ram_past_top", 32'h0000_1000, 32'd0);
    expectRead("ram_low_bits_ignored", 32'h0000_0043, 32'hDEAD_BEEF);

    // GPIO output register and two-stage input synchronizer
    applyStimulus(A_GPIO_OUT, 32'h0000_A5A5);
    gpio_in = 16'h00FF;
    checkOutput("gpio_out_pin", 32'(gpio_out), 32'h0000_A5A5);
    expectRead("gpio_out_rd", A_GPIO_OUT, 32'h0000_A5A5);
    waitCycles(1);
    expectRead("gpio_in_plus1", A_GPIO_IN, 32'd0);
    waitCycles(1);
    expectRead("gpio_in_plus2", A_GPIO_IN, 32'h0000_00FF);
    applyStimulus(A_GPIO_IN, 32'h0000_1234);
    expectRead("gpio_in_ro", A_GPIO_IN, 32'h0000_00FF);
    applyStimulus(32'hFFFF_0008, 32'hFFFF_FFFF);
    expectRead("io_unmapped", 32'hFFFF_0008, 32'd0);
    checkOutput("gpio_out_hold", 32'(gpio_out), 32'h0000_A5A5);

`ifdef MIPS_DMEM_TIMER_EN
    // Auto-reload: match on the 6th enabled tick
    applyStimulus(A_TCMP, 32'd5);
    applyStimulus(A_TCTRL, 32'd3);
    for (int i = 1; i <= 5; i++) begin
      waitCycles(1);
      expectRead($sformatf("auto_count_%0d", i), A_TCOUNT, 32'(i));
      checkOutput($sformatf("auto_irq_low_%0d", i), {31'd0, timer_irq}, 32'd0);
    end
    waitCycles(1);
    checkOutput("auto_irq_high", {31'd0, timer_irq}, 32'd1);
    expectRead("auto_tstat", A_TSTAT, 32'd1);
    expectRead("auto_reload", A_TCOUNT, 32'd0);
    applyStimulus(A_TSTAT, 32'd1);
    checkOutput("auto_irq_cleared", {31'd0, timer_irq}, 32'd0);
    expectRead("auto_tstat_cleared", A_TSTAT, 32'd0);
    expectRead("auto_count_after", A_TCOUNT, 32'd1);
    applyStimulus(A_TCTRL, 32'd0);
    applyStimulus(A_TCOUNT, 32'd0);
    waitCycles(2);
    expectRead("disabled_hold", A_TCOUNT, 32'd0);

    // One-shot
    applyStimulus(A_TCMP, 32'd3);
    applyStimulus(A_TCTRL, 32'd1);
    waitCycles(6);
    expectRead("oneshot_count", A_TCOUNT, 32'd3);
    expectRead("oneshot_tctrl", A_TCTRL, 32'd0);
    expectRead("oneshot_tstat", A_TSTAT, 32'd1);
    checkOutput("oneshot_irq", {31'd0, timer_irq}, 32'd1);
    applyStimulus(A_TSTAT, 32'd1);
    expectRead("oneshot_cleared", A_TSTAT, 32'd0);

    // Wrap without flag, then clear coinciding with match
    applyStimulus(A_TCMP, 32'h0000_0010);
    applyStimulus(A_TCOUNT, 32'hFFFF_FFFF);
    expectRead("wrap_preload", A_TCOUNT, 32'hFFFF_FFFF);
    applyStimulus(A_TCTRL, 32'd1);
    waitCycles(1);
    expectRead("wrap_to_zero", A_TCOUNT, 32'd0);
    expectRead("wrap_no_match", A_TSTAT, 32'd0);
    waitCycles(16);
    expectRead("wrap_reach_cmp", A_TCOUNT, 32'h0000_0010);
    expectRead("wrap_pre_match", A_TSTAT, 32'd0);
    applyStimulus(A_TSTAT, 32'd1);
    expectRead("match_beats_clear", A_TSTAT, 32'd1);
    checkOutput("match_beats_clear_irq", {31'd0, timer_irq}, 32'd1);
    expectRead("match_oneshot_hold", A_TCOUNT, 32'h0000_0010);
    applyStimulus(A_TSTAT, 32'd1);
    expectRead("clear_after_match", A_TSTAT, 32'd0);

    applyStimulus(A_TCMP, 32'd100);
    applyStimulus(A_TCTRL, 32'd3);
`else
    applyStimulus(A_TCMP, 32'd5);
    applyStimulus(A_TCTRL, 32'd3);
    waitCycles(8);
    expectRead("notimer_tcmp", A_TCMP, 32'd0);
    expectRead("notimer_tctrl", A_TCTRL, 32'd0);
    expectRead("notimer_tcount", A_TCOUNT, 32'd0);
    expectRead("notimer_tstat", A_TSTAT, 32'd0);
    checkOutput("notimer_irq", {31'd0, timer_irq}, 32'd0);
`endif

    // Reset mid-run, with a store in the same cycle that must be dropped
    applyStimulus(32'h0000_0044, 32'h1111_1111);
    waitCycles(3);
    reset            = 1'b0;
    bus.memaddr      = 32'h0000_0044;
    bus.memwritedata = 32'hBAD0_BAD0;
    bus.memwrite     = 1'b1;
    @(posedge clk);
    #1;
    bus.memwrite = 1'b0;
    reset        = 1'b1;
    checkOutput("rst2_gpio_out", 32'(gpio_out), 32'd0);
    checkOutput("rst2_irq", {31'd0, timer_irq}, 32'd0);
    expectRead("rst2_tcount", A_TCOUNT, 32'd0);
    expectRead("rst2_tctrl", A_TCTRL, 32'd0);
`ifdef MIPS_DMEM_TIMER_EN
    expectRead("rst2_tcmp", A_TCMP, 32'hFFFF_FFFF);
`else
    expectRead("rst2_tcmp", A_TCMP, 32'd0);
`endif
    expectRead("rst2_tstat", A_TSTAT, 32'd0);
    expectRead("rst2_gpio_in", A_GPIO_IN, 32'd0);
    expectRead("rst2_ram_40_kept", 32'h0000_0040, 32'hDEAD_BEEF);
    expectRead("rst2_write_dropped", 32'h0000_0044, 32'h1111_1111);
    waitCycles(1);
    expectRead("rst2_tcount_idle", A_TCOUNT, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/mips_dmem_io_responder.md
Name: mips_dmem_io_responder

Overview:
- Data-side bus responder for the pipelined MIPS core: serves the core's MEM-stage word accesses (memwrite / memaddr / memwritedata / memreaddata).
- Decodes each address into one of three targets: word RAM, a GPIO block, or a timer/compare peripheral with an interrupt line.
- Reads are same-cycle, because the core registers memreaddata at the MEM/WB boundary. Writes commit on the rising clk edge.

Parameters:
- RAM_AW, 10, RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- GPIO_W, 16, GPIO input and output width.
- PRESC, 1, timer prescaler: TCOUNT advances once every PRESC enabled cycles (PRESC >= 1).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- memwrite  in  1  write strobe from the core's MEM stage
- memaddr  in  32  byte address; bits [1:0] ignored
- memwritedata  in  32  store data
- memreaddata  out  32  load data, combinational from memaddr and current state
- gpio_in  in  GPIO_W  external inputs
- gpio_out  out  GPIO_W  GPIO_OUT register
- timer_irq  out  1  equals TSTAT[0]

Behaviour:
- Reset: clk and reset only; reset (active-low, synchronous) is sampled on the rising clk edge.
  - Cleared to 0: gpio_out, TCTRL, TCOUNT, TSTAT, prescale counter, both synchronizer stages.
  - TCMP resets to 0xFFFF_FFFF.
  - timer_irq = 0.
  - RAM contents are not cleared.
  - Reset asserted mid-count aborts counting; a write in the same cycle as reset is dropped.
- Address map (word aligned):
  - RAM: memaddr[31:16]==0 and memaddr[15:2] < 2^RAM_AW; RAM index = memaddr[RAM_AW+1:2].
  - 0xFFFF_0000 GPIO_OUT (RW)
  - 0xFFFF_0004 GPIO_IN (RO)
  - 0xFFFF_0010 TCTRL (RW): bit0 EN, bit1 AUTO
  - 0xFFFF_0014 TCOUNT (RW)
  - 0xFFFF_0018 TCMP (RW)
  - 0xFFFF_001C TSTAT (bit0 MATCH; write 1 to clear)
  - Unmapped: reads return 0; writes are ignored.
- Read path:
  - Purely combinational and registered nowhere.
  - Returns pre-edge state: a write and a read to the same address in the same cycle return the old value.
  - Narrow registers are zero-extended; unused TCTRL/TSTAT bits read 0.
- GPIO_IN: gpio_in passes through a 2-flop synchronizer; a read returns the second stage, so input-to-readable latency is 2 cycles.
- Timer prescaler:
  - While EN=1, the prescale counter counts 0..PRESC-1.
  - A tick fires when the prescale counter equals PRESC-1, then it wraps to 0.
  - While EN=0 the prescale counter holds at 0.
- Timer tick:
  - If TCOUNT==TCMP: MATCH<=1.
    - AUTO=1: TCOUNT<=0.
    - AUTO=0: TCOUNT holds and EN<=0 (one-shot).
  - Otherwise TCOUNT<=TCOUNT+1, modulo 2^32 (wraps 0xFFFF_FFFF to 0 with no flag).
- Simultaneous events:
  - CPU write to TCOUNT or TCTRL beats a tick update in the same cycle.
  - A MATCH set beats a write-1-to-clear in the same cycle.
  - Writing TCMP takes effect for compares from the next cycle.
- Latency: register writes are visible to reads 1 cycle after the write edge; timer_irq rises 1 cycle after the matching tick edge.

Optional Feature:
- Macro: MIPS_DMEM_TIMER_EN.
- Defined: timer registers, prescaler and timer_irq are implemented as above.
- Undefined:
  - No timer logic is generated.
  - Addresses 0xFFFF_0010..0xFFFF_001C read 0 and ignore writes.
  - timer_irq is tied to 0.
  - RAM and GPIO are unchanged.

Decomposition:
- Shared package holds:
  - address constants: IO_BASE 0xFFFF_0000, GPIO_OUT_OFS, GPIO_IN_OFS, TCTRL_OFS, TCOUNT_OFS, TCMP_OFS, TSTAT_OFS;
  - TCTRL bit indices EN_BIT=0, AUTO_BIT=1;
  - TCMP reset value.
- One sub-module, mips_dmem_timer: prescaler, TCOUNT/TCMP/TCTRL/TSTAT and irq. It takes a decoded write strobe, register select and wdata, and returns read data. The top level keeps RAM, GPIO, address decode and the read mux.

Test Plan:
- Reset, then store 0x1234_5678 to 0x0000_0040 and load 0x0000_0040 -> memreaddata=0x1234_5678 the cycle after the write; a load from 0x0001_0000 -> 0.
- Write GPIO_OUT=0xA5A5, then drive gpio_in=0x00FF -> gpio_out=0xA5A5 the next cycle; GPIO_IN reads 0 at +1 cycle and 0x00FF from +2 cycles.
- PRESC=1; TCMP=5, TCTRL=0b11 -> MATCH and timer_irq rise at the 6th enabled tick; TCOUNT returns to 0; write TSTAT=1 -> irq drops the next cycle.
- One-shot: TCMP=3, TCTRL=0b01 -> MATCH set, TCOUNT holds at 3, TCTRL reads 0.
- TCOUNT=0xFFFF_FFFF with TCMP=0x10, EN=1 -> TCOUNT wraps to 0 with MATCH=0; a clear write coinciding with a match leaves MATCH=1.
- Pull reset low while counting -> next edge: TCOUNT=0, TCTRL=0, TCMP=0xFFFF_FFFF, gpio_out=0; a RAM word written before reset is still readable.
